// File: rtl/viterbi_chk_pkg.sv
// Purpose: shared state encoding and default constants for the BER checker.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
`timescale 1ns/1ps
package viterbi_chk_pkg;

    // Alignment state machine states
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int DEF_DEPTH        = 64;
    localparam int DEF_SYNC_LEN     = 16;
    localparam int DEF_SYNC_MAX_ERR = 2;
    localparam int DEF_LOSS_ERR     = 8;
    localparam int DEF_CNT_W        = 16;

endpackage

// File: rtl/bit_fifo.sv
// Purpose: one-bit synchronous FIFO, pops up to two entries per cycle.
// Latency: a pushed bit is visible at the head / in count one cycle after push.
// Backpressure: none; a push while full is accepted only if a pop frees space.
`timescale 1ns/1ps
module bit_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     din,
    input  logic [1:0]               pop_num,
    output logic                     dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0] mem;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             accept;

    // pop_num must never exceed count; the caller clamps it
    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign dout   = mem[rd_ptr];
    assign accept = push && (!full || (pop_num != 2'd0));

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; reset discards contents immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop_num);
            wr_ptr <= wr_ptr + AW'(accept);
            count  <= count + CW'(accept) - CW'(pop_num);
        end
    end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Purpose: aligns buffered tx bits with decoder output, counts compares and errors once locked.
// Latency: counters, flags and lock state update on the edge after the rx_valid_i cycle.
// Backpressure: none; tx bits are dropped when full (overflow_o), rx bits discarded when empty (underrun_o).
`timescale 1ns/1ps
module viterbi_ber_checker
    import viterbi_chk_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int SYNC_LEN     = DEF_SYNC_LEN,
    parameter int SYNC_MAX_ERR = DEF_SYNC_MAX_ERR,
    parameter int LOSS_ERR     = DEF_LOSS_ERR,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tx_valid_i,
    input  logic             tx_bit_i,
    input  logic             rx_valid_i,
    input  logic             rx_bit_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic [CNT_W-1:0] bit_count_o,
    output logic [CNT_W-1:0] err_count_o,
    output logic             overflow_o,
    output logic             underrun_o,
    output logic             sat_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(SYNC_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    chk_state_t       state;
    logic [WW-1:0]    win_cnt;
    logic [WW-1:0]    win_err;
    logic [WW-1:0]    err_total;
    logic             win_last;

    logic             head;
    logic             full;
    logic             empty;
    logic [CW-1:0]    count;
    logic [1:0]       pop_num;

    logic             compare;
    logic             mismatch;
    logic             drop_evt;
    logic             underrun_evt;
    logic [CNT_W-1:0] bit_nxt;
    logic [CNT_W-1:0] err_nxt;

    bit_fifo #(
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tx_valid_i),
        .din     (tx_bit_i),
        .pop_num (pop_num),
        .dout    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Compare/pop decode; SLIP drops one extra entry beyond the rx bit's own
    always_comb begin
        compare      = rx_valid_i && !empty && (state != SLIP);
        mismatch     = compare && (head != rx_bit_i);
        underrun_evt = rx_valid_i && empty;
        pop_num      = 2'd0;
        if (state == SLIP) begin
            if (rx_valid_i && (count > CW'(1))) begin
                pop_num = 2'd2;
            end else if (!empty) begin
                pop_num = 2'd1;
            end
        end else if (compare) begin
            pop_num = 2'd1;
        end
        drop_evt  = tx_valid_i && full && (pop_num == 2'd0);
        err_total = win_err + WW'(mismatch);
        win_last  = compare && (win_cnt == WW'(SYNC_LEN - 1));
    end

    // Saturating next values for the statistics counters
    always_comb begin
        bit_nxt = bit_count_o;
        err_nxt = err_count_o;
        if (compare && (state == LOCKED)) begin
            if (bit_count_o != CNT_MAX) begin
                bit_nxt = bit_count_o + CNT_W'(1);
            end
            if (mismatch && (err_count_o != CNT_MAX)) begin
                err_nxt = err_count_o + CNT_W'(1);
            end
        end
    end

    // Alignment FSM with window counters cleared on every state entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SEARCH;
            win_cnt <= '0;
            win_err <= '0;
        end else begin
            case (state)
                SLIP: begin
                    state   <= SEARCH;
                    win_cnt <= '0;
                    win_err <= '0;
                end
                default: begin
                    if (win_last) begin
                        win_cnt <= '0;
                        win_err <= '0;
                        if (state == SEARCH) begin
                            state <= (err_total <= WW'(SYNC_MAX_ERR)) ? LOCKED : SLIP;
                        end else if (err_total >= WW'(LOSS_ERR)) begin
                            state <= SEARCH;
                        end
                    end else if (compare) begin
                        win_cnt <= win_cnt + WW'(1);
                        win_err <= err_total;
                    end
                end
            endcase
        end
    end

    assign locked_o = (state == LOCKED);

    // Statistics and sticky flags; clear_i overrides any same-cycle update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_count_o <= '0;
            err_count_o <= '0;
            overflow_o  <= 1'b0;
            underrun_o  <= 1'b0;
            sat_o       <= 1'b0;
        end else if (clear_i) begin
            bit_count_o <= '0;
            err_count_o <= '0;
            overflow_o  <= 1'b0;
            underrun_o  <= 1'b0;
            sat_o       <= 1'b0;
        end else begin
            bit_count_o <= bit_nxt;
            err_count_o <= err_nxt;
            overflow_o  <= overflow_o | drop_evt;
            underrun_o  <= underrun_o | underrun_evt;
            sat_o       <= sat_o | (&bit_nxt) | (&err_nxt);
        end
    end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Purpose: scoreboard bench for viterbi_ber_checker (default and 4-bit counter instances).
// Latency: expectations are for outputs one edge after each driven cycle.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_viterbi_ber_checker;

    localparam int DEPTH        = 64;
    localparam int SYNC_LEN     = 16;
    localparam int SYNC_MAX_ERR = 2;
    localparam int LOSS_ERR     = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx_valid = 1'b0, tx_bit = 1'b0, rx_valid = 1'b0, rx_bit = 1'b0, clear = 1'b0;

    logic        a_locked, a_ovf, a_und, a_sat;
    logic [15:0] a_bits, a_errs;
    logic        b_locked, b_ovf, b_und, b_sat;
    logic [3:0]  b_bits, b_errs;

    always #5 clk = ~clk;

    viterbi_ber_checker #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit),
        .rx_valid_i(rx_valid), .rx_bit_i(rx_bit), .clear_i(clear),
        .locked_o(a_locked), .bit_count_o(a_bits), .err_count_o(a_errs),
        .overflow_o(a_ovf), .underrun_o(a_und), .sat_o(a_sat));

    viterbi_ber_checker #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .tx_valid_i(tx_valid), .tx_bit_i(tx_bit),
        .rx_valid_i(rx_valid), .rx_bit_i(rx_bit), .clear_i(clear),
        .locked_o(b_locked), .bit_count_o(b_bits), .err_count_o(b_errs),
        .overflow_o(b_ovf), .underrun_o(b_und), .sat_o(b_sat));

    typedef struct {
        bit locked;
        int bits;
        int errs;
        bit ovf;
        bit und;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rises    = 0;
    int   falls    = 0;
    bit   prev_lock = 1'b0;

    // Reference model: transmit buffer as a queue, mode 0=search 1=slip 2=locked
    bit mq[$];
    int m_mode, m_win, m_werr, m_bits, m_errs;
    bit m_ovf, m_und;

    function automatic void model_reset();
        mq.delete();
        m_mode = 0; m_win = 0; m_werr = 0; m_bits = 0; m_errs = 0;
        m_ovf = 1'b0; m_und = 1'b0;
    endfunction

    function automatic void model_step(bit tv, bit tb, bit rv, bit rb, bit clr);
        bit h;
        int mm;
        int n;
        if (m_mode == 1) begin
            n = rv ? 2 : 1;
            if (rv && mq.size() == 0) m_und = 1'b1;
            for (int k = 0; k < n; k++) if (mq.size() > 0) void'(mq.pop_front());
            m_mode = 0; m_win = 0; m_werr = 0;
        end else if (rv) begin
            if (mq.size() == 0) begin
                m_und = 1'b1;
            end else begin
                h = mq.pop_front();
                mm = (h != rb) ? 1 : 0;
                m_win += 1;
                m_werr += mm;
                if (m_mode == 2) begin
                    m_bits += 1;
                    m_errs += mm;
                end
                if (m_win == SYNC_LEN) begin
                    if (m_mode == 0) m_mode = (m_werr <= SYNC_MAX_ERR) ? 2 : 1;
                    else if (m_werr >= LOSS_ERR) m_mode = 0;
                    m_win = 0; m_werr = 0;
                end
            end
        end
        if (tv) begin
            if (mq.size() < DEPTH) mq.push_back(tb);
            else m_ovf = 1'b1;
        end
        if (clr) begin
            m_bits = 0; m_errs = 0; m_ovf = 1'b0; m_und = 1'b0;
        end
    endfunction

    task automatic chk(input string name, input int got, input int expv);
        n_checks++;
        if (got != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    // Drive one cycle of inputs and queue the state expected after the next edge
    task automatic step(input bit tv, input bit tb, input bit rv, input bit rb, input bit clr);
        exp_t e;
        @(posedge clk);
        #2;
        tx_valid = tv; tx_bit = tb; rx_valid = rv; rx_bit = rb; clear = clr;
        model_step(tv, tb, rv, rb, clr);
        e.locked = (m_mode == 2);
        e.bits = m_bits; e.errs = m_errs; e.ovf = m_ovf; e.und = m_und;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Assert reset between edges; optionally verify every output drops at once
    task automatic do_reset(input bit check_out);
        idle();
        idle();
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        if (check_out) begin
            chk("rst_locked", int'(a_locked), 0);
            chk("rst_bits",   int'(a_bits),   0);
            chk("rst_errs",   int'(a_errs),   0);
            chk("rst_ovf",    int'(a_ovf),    0);
            chk("rst_und",    int'(a_und),    0);
            chk("rst_sat",    int'(a_sat),    0);
            chk("rst_small",  int'({b_locked, b_bits, b_errs, b_ovf, b_und, b_sat}), 0);
        end
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    // Monitor: one scoreboard comparison per clock while expectations are queued
    initial begin
        exp_t e;
        int eb16, ee16, eb4, ee4;
        bit es16, es4;
        forever begin
            @(posedge clk);
            #1;
            if (a_locked && !prev_lock) rises++;
            if (!a_locked && prev_lock) falls++;
            prev_lock = a_locked;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                eb16 = (e.bits > 65535) ? 65535 : e.bits;
                ee16 = (e.errs > 65535) ? 65535 : e.errs;
                eb4  = (e.bits > 15) ? 15 : e.bits;
                ee4  = (e.errs > 15) ? 15 : e.errs;
                es16 = (e.bits >= 65535) || (e.errs >= 65535);
                es4  = (e.bits >= 15) || (e.errs >= 15);
                n_checks++;
                if (a_locked != e.locked || int'(a_bits) != eb16 || int'(a_errs) != ee16 ||
                    a_ovf != e.ovf || a_und != e.und || a_sat != es16 ||
                    b_locked != e.locked || int'(b_bits) != eb4 || int'(b_errs) != ee4 ||
                    b_ovf != e.ovf || b_und != e.und || b_sat != es4) begin
                    n_fail++;
                    $display("FAIL scoreboard t=%0t: got lock=%0d bits=%0d errs=%0d ovf=%0d und=%0d sat=%0d small(lock=%0d bits=%0d errs=%0d ovf=%0d und=%0d sat=%0d) expected lock=%0d bits=%0d errs=%0d ovf=%0d und=%0d sat=%0d small(bits=%0d errs=%0d sat=%0d)",
                             $time, a_locked, a_bits, a_errs, a_ovf, a_und, a_sat,
                             b_locked, b_bits, b_errs, b_ovf, b_und, b_sat,
                             e.locked, eb16, ee16, e.ovf, e.und, es16, eb4, ee4, es4);
                end
            end
        end
    end

    // rx replays the tx bits from index skip onward, lat cycles later.
    // mode 1: two inverted bits per 32 after lock; mode 2: eight inverted bits in one locked window.
    task automatic stream(input int ntx, input int lat, input int skip, input int mode, input int rst_at);
        bit bits[512];
        int j;
        bit rv, rb, inv;
        for (int i = 0; i < ntx; i++) begin
            if (skip == 1 && i < 17) bits[i] = bit'(i & 1);
            else bits[i] = bit'($urandom_range(1, 0));
        end
        rises = 0;
        falls = 0;
        for (int c = 0; c < lat + ntx - skip + 1; c++) begin
            if (c == rst_at) begin
                do_reset(1'b1);
                break;
            end
            j   = c - lat;
            rv  = (j >= 0) && (j < ntx - skip);
            inv = (mode == 1 && j >= 16 && ((j - 16) % 32) < 2) ||
                  (mode == 2 && j >= 32 && j < 40);
            rb  = rv ? (bits[j + skip] ^ inv) : 1'b0;
            step(c < ntx, (c < ntx) ? bits[c] : 1'b0, rv, rb, 1'b0);
        end
        idle();
    endtask

    initial begin
        bit ob[65];
        bit tv, rv, rb, clr;
        model_reset();
        #1 rst = 1'b0;
        #1;
        chk("init_locked", int'(a_locked), 0);
        chk("init_bits",   int'(a_bits),   0);
        chk("init_errs",   int'(a_errs),   0);
        chk("init_flags",  int'({a_ovf, a_und, a_sat}), 0);
        chk("init_small",  int'({b_locked, b_bits, b_errs, b_ovf, b_und, b_sat}), 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;

        // Aligned PRBS stream, 20-cycle decoder latency
        stream(200, 20, 0, 0, -1);
        chk("aligned_bits",   int'(a_bits),   184);
        chk("aligned_errs",   int'(a_errs),   0);
        chk("aligned_locked", int'(a_locked), 1);
        chk("aligned_rises",  rises,          1);
        chk("aligned_sat",    int'(a_sat),    0);
        chk("small_sat_bits", int'(b_bits),   15);
        chk("small_sat_flag", int'(b_sat),    1);

        // Clear keeps lock but zeroes statistics
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("clear_bits",   int'(a_bits),   0);
        chk("clear_small",  int'({b_bits, b_sat}), 0);
        chk("clear_locked", int'(a_locked), 1);

        // One-bit offset needs exactly one slip
        do_reset(1'b0);
        stream(100, 20, 1, 0, -1);
        chk("offset_bits",   int'(a_bits),   66);
        chk("offset_errs",   int'(a_errs),   0);
        chk("offset_rises",  rises,          1);
        chk("offset_locked", int'(a_locked), 1);

        // Injected error pairs while locked
        do_reset(1'b0);
        stream(272, 20, 0, 1, -1);
        chk("inj_bits",   int'(a_bits),   256);
        chk("inj_errs",   int'(a_errs),   16);
        chk("inj_falls",  falls,          0);
        chk("inj_locked", int'(a_locked), 1);
        chk("inj_small",  int'(b_errs),   15);

        // Loss of lock and re-acquisition
        do_reset(1'b0);
        stream(120, 20, 0, 2, -1);
        chk("loss_falls",  falls,          1);
        chk("loss_rises",  rises,          2);
        chk("loss_locked", int'(a_locked), 1);
        chk("loss_errs",   int'(a_errs),   8);
        chk("loss_bits",   int'(a_bits),   88);

        // Reset in the middle of a locked stream with a full-ish buffer
        do_reset(1'b0);
        stream(200, 20, 0, 0, 100);

        // Overflow then underrun
        do_reset(1'b0);
        for (int i = 0; i < 65; i++) begin
            ob[i] = bit'($urandom_range(1, 0));
            step(1'b1, ob[i], 1'b0, 1'b0, 1'b0);
        end
        idle();
        chk("ovf_flag", int'(a_ovf), 1);
        chk("ovf_und",  int'(a_und), 0);
        for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, ob[i], 1'b0);
        idle();
        chk("und_before", int'(a_und),    0);
        chk("und_locked", int'(a_locked), 1);
        chk("und_bits",   int'(a_bits),   48);
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("und_after", int'(a_und), 1);

        // Randomised traffic: rx-heavy phase then tx-heavy phase
        do_reset(1'b0);
        for (int p = 0; p < 2; p++) begin
            for (int c = 0; c < 1500; c++) begin
                tv  = $urandom_range(99, 0) < ((p == 0) ? 50 : 85);
                rv  = $urandom_range(99, 0) < ((p == 0) ? 85 : 30);
                clr = ($urandom_range(199, 0) == 0);
                if (mq.size() > 0 && $urandom_range(19, 0) != 0) rb = mq[0];
                else rb = bit'($urandom_range(1, 0));
                step(tv, bit'($urandom_range(1, 0)), rv, rb, clr);
            end
        end
        idle();
        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/viterbi_ber_checker.md
# viterbi_ber_checker

Receive-side bit-error-rate checker for the convolutional encoder / Viterbi decoder loopback. It buffers the transmitted information bits, aligns them against the decoder output stream, and counts compared bits and bit errors once aligned. It sits beside the decoder at the far end of the link from the channel error injector and measures what the injector corrupted and the decoder failed to correct.

## Interface
Parameters:
- DEPTH, 64: transmit-bit buffer depth; power of 2, at least 4.
- SYNC_LEN, 16: compares per alignment or loss-of-lock window.
- SYNC_MAX_ERR, 2: maximum mismatches in a SEARCH window for lock.
- LOSS_ERR, 8: mismatches in one LOCKED window that force return to SEARCH.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: reset, asynchronous, active-low.
- tx_valid_i, input, 1: tx_bit_i is a transmitted information bit.
- tx_bit_i, input, 1: bit fed to the encoder.
- rx_valid_i, input, 1: rx_bit_i is a decoded bit.
- rx_bit_i, input, 1: decoder output bit.
- clear_i, input, 1: synchronous clear of counters and sticky flags.
- locked_o, output, 1: alignment achieved.
- bit_count_o, output, CNT_W: bits compared while LOCKED.
- err_count_o, output, CNT_W: mismatches while LOCKED.
- overflow_o, output, 1: sticky; a tx bit was dropped because the buffer was full.
- underrun_o, output, 1: sticky; an rx bit arrived with the buffer empty.
- sat_o, output, 1: sticky; a counter reached all-ones.

## Operation
- Buffer: FIFO of DEPTH one-bit entries with a log2(DEPTH)+1 bit occupancy count.
  - tx_valid_i pushes when not full. When full, the bit is dropped and overflow_o is set.
  - Push and pop in the same cycle are always legal, including when full or empty-with-push. A simultaneous push and pop leaves occupancy unchanged.
- Pop and compare: rx_valid_i with the buffer non-empty pops the head and compares it with rx_bit_i. rx_valid_i with the buffer empty sets underrun_o; the rx bit is discarded and no compare occurs.
- States: SEARCH, SLIP, LOCKED. The state encoding lives in the shared package. A window counter and a window error counter are both cleared on every state entry.
  - SEARCH: each compare increments the window counter and, on mismatch, the window error counter.
    - At the SYNC_LEN-th compare, go to LOCKED if the window error total (including this compare) is at most SYNC_MAX_ERR; otherwise go to SLIP.
  - SLIP: lasts exactly one cycle. It pops and discards one buffer entry if non-empty. If rx_valid_i is high in SLIP, that rx bit also pops and discards its own entry, with no compare. The net alignment shift is exactly one bit. Next state is SEARCH.
  - LOCKED: each compare increments bit_count_o and, on mismatch, err_count_o. The window logic runs as in SEARCH.
    - At the SYNC_LEN-th compare, if the window errors are at least LOSS_ERR, go to SEARCH; otherwise restart the window and stay LOCKED.
- Counters: bit_count_o and err_count_o saturate at 2^CNT_W-1 and never wrap. sat_o is set in the cycle either counter reaches all-ones.
- clear_i: zeroes bit_count_o, err_count_o, overflow_o, underrun_o and sat_o. The buffer, the FSM and the window counters are unaffected. If clear_i coincides with a compare, the clear wins and the counters read 0.
- locked_o is 1 exactly when the state is LOCKED.

## Timing
- Reset: all outputs 0, buffer empty, state SEARCH, window counters 0. Reset mid-stream discards buffer contents immediately.
- Counters, flags and state are registered. Values reflect an rx_valid_i cycle on the next rising edge.
- locked_o rises on the edge ending the cycle of the SYNC_LEN-th passing SEARCH compare.
- SLIP to SEARCH takes one cycle. Buffer occupancy is visible internally one cycle after a push.
- Alignment range: decoder latency up to DEPTH-1 bits. A larger latency causes overflow_o.

## Structure
- Package viterbi_chk_pkg holds the state enum typedef (SEARCH, SLIP, LOCKED) and the default parameter constants.
- Sub-module bit_fifo: one-bit synchronous FIFO with push, pop, full, empty and count outputs. The FSM, windowing and counters stay in the top level.

## Test plan
- Aligned stream: 200 PRBS tx bits, with the same bits on rx delayed 20 cycles and no errors -> locked_o high after 16 rx bits, final bit_count_o=184, err_count_o=0.
- Offset: rx stream omits the first tx bit -> exactly one SLIP, lock after the second window, err_count_o=0.
- Injected errors: two consecutive inverted rx bits per 32 after lock, 256 locked compares -> err_count_o=16, locked_o stays 1.
- Loss of lock: after lock, invert 8 bits within one 16-bit window -> locked_o falls at window end, then re-locks on clean data.
- Overflow/underrun: 65 pushes with no pops -> overflow_o=1. Then 65 rx bits -> underrun_o=1 on the 65th.
- Saturation/clear/reset: with CNT_W=4, 20 locked compares -> bit_count_o=15 and sat_o=1. clear_i -> all zero with locked_o still 1. rst low mid-stream -> every output 0 immediately.
